// File: rtl/serial_alu_w.sv
// ---------------------------------------------------------------------------
// serial_alu_w -- digit-serial ALU
//
// Processes WIDTH-bit operands DIGIT bits per clock, LSB first, and finishes
// an operation in N = WIDTH/DIGIT cycles. Eight operations:
//   0 add (c = carry out)        4 xor  (c = ^A)
//   1 sub (c = no borrow, A>=B)  5 xnor (c = A==B)
//   2 or  (c = |A)               6 pass A (c = A>B, unsigned)
//   3 and (c = &A)               7 shift left by 1 (c = A[WIDTH-1])
//
// Parameters:
//   WIDTH  operand/result width, 2..64
//   DIGIT  bits per clock, 1/2/4/8, must divide WIDTH
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled only while idle
//   opcode  in   operation select (3 bits)
//   a_in    in   operand A (WIDTH)
//   b_in    in   operand B (WIDTH)
//   busy    out  operation in progress
//   done    out  one-cycle completion pulse
//   y       out  result (WIDTH), held until the next completion
//   c       out  flag, held until the next completion
//   z       out  zero flag of y; only with SERIAL_ALU_ZFLAG_EN defined
//
// Optional feature macro: SERIAL_ALU_ZFLAG_EN (adds port z and its logic).
// ---------------------------------------------------------------------------
module serial_alu_w #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c
`ifdef SERIAL_ALU_ZFLAG_EN
  ,
  output logic             z
`endif
);

  // -------------------------------------------------------------------------
  // Parameter legality
  // -------------------------------------------------------------------------
  generate
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8) ||
        WIDTH < 2 || WIDTH > 64 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_alu_w: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_SHL  = 3'd7
  } op_t;

  // -------------------------------------------------------------------------
  // Registers and nets
  // -------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;      // digits already consumed in this operation
  op_t              r_op;
  logic [WIDTH-1:0] r_a;        // operand shift registers, consumed LSB first
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;      // partial result, filled from the MSB side
  logic             r_flag;     // serial carry / compare / reduction state
  logic [WIDTH-1:0] r_y;
  logic             r_c;
  logic             r_done;

  logic             w_first;    // current RUN edge handles the lowest digit
  logic             w_last;     // current RUN edge handles the highest digit
  logic             w_flag_in;
  logic             w_flag_nxt;
  logic [DIGIT-1:0] w_dig_y;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_state == S_RUN) && (r_cnt == LAST_CNT);

  // The serial state register is cleared on capture; ops whose chain starts
  // at 1 (sub carry-in, and/eq reductions) pick their seed on the first digit.
  assign w_flag_in = w_first ? (r_op inside {OP_SUB, OP_AND, OP_XNOR}) : r_flag;

  // -------------------------------------------------------------------------
  // Digit slice: DIGIT result bits and the updated serial flag
  // -------------------------------------------------------------------------
  always_comb begin
    logic f;
    logic ab;
    logic bb;
    // NOTE: every variable written here gets a value before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    f       = w_flag_in;
    ab      = 1'b0;
    bb      = 1'b0;
    w_dig_y = '0;
    for (int i = 0; i < DIGIT; i++) begin
      ab = r_a[i];
      bb = r_b[i];
      case (r_op)
        OP_ADD: begin
          w_dig_y[i] = ab ^ bb ^ f;
          f          = (ab & bb) | (f & (ab ^ bb));
        end
        OP_SUB: begin
          // A + ~B + 1: the seed carry is the +1, carry out means no borrow
          w_dig_y[i] = ab ^ ~bb ^ f;
          f          = (ab & ~bb) | (f & (ab ^ ~bb));
        end
        OP_OR: begin
          w_dig_y[i] = ab | bb;
          f          = f | ab;
        end
        OP_AND: begin
          w_dig_y[i] = ab & bb;
          f          = f & ab;
        end
        OP_XOR: begin
          w_dig_y[i] = ab ^ bb;
          f          = f ^ ab;
        end
        OP_XNOR: begin
          w_dig_y[i] = ~(ab ^ bb);
          f          = f & ~(ab ^ bb);
        end
        OP_PASS: begin
          w_dig_y[i] = ab;
          // bits arrive LSB first, so a later differing bit outranks earlier ones
          if (ab != bb) f = ab;
        end
        OP_SHL: begin
          // flag carries the previous A bit one position up
          w_dig_y[i] = f;
          f          = ab;
        end
      endcase
    end
    w_flag_nxt = f;
  end

  // New digit enters at the top; the cast drops the DIGIT bits shifted out.
  assign w_res_nxt = WIDTH'({w_dig_y, r_res} >> DIGIT);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values; blocking assignments here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy = (r_state == S_RUN);
    done = r_done;
    y    = r_y;
    c    = r_c;
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand and result shift registers are reset too, so a
      // reset leaves no stale operand or partial result anywhere.
      r_cnt  <= '0;
      r_op   <= OP_ADD;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_flag <= 1'b0;
      r_y    <= '0;
      r_c    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op_t'(opcode);
            r_a    <= a_in;
            r_b    <= b_in;
            r_res  <= '0;
            r_flag <= 1'b0;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_a    <= r_a >> DIGIT;
          r_b    <= r_b >> DIGIT;
          r_res  <= w_res_nxt;
          r_flag <= w_flag_nxt;
          if (w_last) begin
            r_cnt  <= '0;
            r_y    <= w_res_nxt;
            r_c    <= w_flag_nxt;
            r_done <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ALU_ZFLAG_EN
  // -------------------------------------------------------------------------
  // Zero flag, accumulated one digit at a time
  // -------------------------------------------------------------------------
  logic r_zacc;   // all result digits so far were zero
  logic r_z;
  logic w_zacc_nxt;

  assign w_zacc_nxt = (w_first ? 1'b1 : r_zacc) & ~(|w_dig_y);
  assign z          = r_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zacc <= 1'b0;
      r_z    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_zacc <= 1'b0;
        S_RUN: begin
          r_zacc <= w_zacc_nxt;
          if (w_last) r_z <= w_zacc_nxt;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: doc/serial_alu_w.md
SERIAL_ALU_W -- requirements
Module: serial_alu_w

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal values are 2..64.
REQ-002 Parameter DIGIT, default 1, bits processed per clock; legal values are 1, 2, 4 and 8, and DIGIT SHALL divide WIDTH; illegal values SHALL stop elaboration.
REQ-003 Ports SHALL be, in order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  operation request.
- opcode  in  3  operation select.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- y  out  WIDTH  result.
- c  out  1  flag output.
- z  out  1  zero flag; present only with SERIAL_ALU_ZFLAG_EN.

Function
REQ-004 Let N = WIDTH/DIGIT; the FSM SHALL have exactly two states: IDLE and RUN.
REQ-005 In IDLE, start=1 at a rising edge SHALL:
- capture opcode, a_in and b_in into internal shift registers;
- clear the result shift register and the serial carry/compare state;
- enter RUN.
REQ-006 In RUN, each edge SHALL consume the DIGIT least-significant bits of A and B, LSB-first, and shift the DIGIT result bits into the result register from the MSB side.
REQ-007 After the Nth RUN edge the FSM SHALL return to IDLE; done=1 and final y/c SHALL be valid for exactly that following cycle.
REQ-008 Latency from the start-sampling edge to done high SHALL be N cycles; busy SHALL be high for exactly those N cycles.
REQ-009 start SHALL be ignored while busy=1; start=1 in the done cycle SHALL be accepted (back-to-back operation, no idle bubble).
REQ-010 y and c SHALL hold their last completed values until the next completion; intermediate partial results SHALL NOT appear on y or c.
REQ-011 Opcodes (all arithmetic modulo 2^WIDTH, with A and B as captured):
- 0: y=A+B, c=carry out.
- 1: y=A-B, c=(A>=B), i.e. no borrow.
- 2: y=A|B, c=|A.
- 3: y=A&B, c=&A.
- 4: y=A^B, c=^A.
- 5: y=~(A^B), c=(A==B).
- 6: y=A, c=(A>B) unsigned.
- 7: y=A<<1, c=A[WIDTH-1].
REQ-012 The add and subtract carry SHALL propagate between digits across edges; subtract SHALL use a carry-in of 1 with B inverted.
REQ-013 The A>B compare SHALL be computed LSB-first: a higher-order differing bit overrides the result from lower bits.
REQ-014 Operands changing on a_in/b_in/opcode during RUN SHALL NOT affect the result.

Reset
REQ-015 rst_n=0 SHALL immediately, without a clock edge, force: state IDLE, busy=0, done=0, y=0, c=0, z=0, and all internal registers to 0.
REQ-016 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-017 The first start after rst_n rises SHALL be honoured at the first rising edge with rst_n=1.

Configuration
REQ-018 With macro SERIAL_ALU_ZFLAG_EN defined:
- port z SHALL exist;
- z SHALL equal (y==0) for the completed result, updated in the done cycle;
- z SHALL be accumulated serially, with no WIDTH-wide compare on y.
REQ-019 Without SERIAL_ALU_ZFLAG_EN, port z and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-020 WIDTH=8, DIGIT=1, op0, A=0xC8, B=0x64 -> done 8 cycles after start; y=0x2C, c=1.
REQ-021 WIDTH=8, DIGIT=2, op1, A=0x10, B=0x20 -> done 4 cycles after start; y=0xF0, c=0; with SERIAL_ALU_ZFLAG_EN and A=B=0x33, y=0x00 and z=1.
REQ-022 WIDTH=16, DIGIT=4, op6 run twice: A=0x8001, B=0x7FFF -> y=0x8001, c=1; A=B=0x1234 -> c=0. Also op5 with A=B -> y=0xFFFF, c=1.
REQ-023 Back-to-back: op7, A=0x81 at edge 0; then start held high in the done cycle with op3, A=0xFF, B=0x0F:
- first result y=0x02, c=1;
- second done exactly 8 cycles later with y=0x0F, c=1;
- start pulses during busy are ignored.
REQ-024 rst_n dropped at RUN cycle 3 -> busy, done, y and c are 0 asynchronously with no done pulse; a new op2, A=0x00, B=0x5A then gives y=0x5A, c=0.
